// File: rtl/la_pkg.sv
// la_pkg: shared state encoding and trigger combine-mode constants for the capture core
package la_pkg;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PRE  = 3'd1,
      WAIT = 3'd2,
      POST = 3'd3,
      DONE = 3'd4
   } la_state_e;

   localparam logic COMB_AND = 1'b0;
   localparam logic COMB_OR  = 1'b1;
endpackage

// File: rtl/la_sample_ram.sv
// la_sample_ram: simple dual-port sample buffer, synchronous write, registered read
module la_sample_ram #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;

   // only the read register is reset; the array itself is not
   always_ff @(posedge clk or posedge rst)
      if (rst) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];

   assign rdata_o = rdata_q;
endmodule

// File: rtl/la_capture.sv
// la_capture: logic-analyzer capture core with masked level/edge trigger and pre-trigger window
module la_capture
   import la_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int TRIG_W = 4,
   parameter int DEPTH  = 256,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_i,
   input  logic [TRIG_W-1:0] trig_i,
   input  logic              arm,
   input  logic              abort,
   input  logic [TRIG_W-1:0] cfg_mask,
   input  logic [TRIG_W-1:0] cfg_value,
   input  logic [TRIG_W-1:0] cfg_edge,
   input  logic              cfg_or,
   input  logic [AW-1:0]     cfg_pretrig,
   output logic [2:0]        state_o,
   output logic              done_o,
   output logic [AW-1:0]     trig_pos_o,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);
   localparam logic [AW-1:0] ONE = AW'(1);

   la_state_e         state_q;
   logic              done_q, or_q, rd_valid_q;
   logic [AW-1:0]     wr_ptr_q, cnt_q, trig_pos_q, pretrig_q;
   logic [TRIG_W-1:0] mask_q, value_q, edge_q, prev_q;
   logic [TRIG_W-1:0] match;
   logic [AW-1:0]     post_len;
   logic              hit, capturing, rd_ok;

   // edge channels additionally need the previous sample to differ from the target
   assign match     = ~(trig_i ^ value_q) & (~edge_q | (prev_q ^ value_q));
   assign hit       = (mask_q == '0) || (or_q == COMB_OR ? |(mask_q & match) : &(match | ~mask_q));
   assign post_len  = ~pretrig_q;
   assign capturing = state_q == PRE || state_q == WAIT || state_q == POST;
   assign rd_ok     = rd_en && state_q == DONE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= IDLE;
         done_q     <= 1'b0;
         or_q       <= 1'b0;
         rd_valid_q <= 1'b0;
         wr_ptr_q   <= '0;
         cnt_q      <= '0;
         trig_pos_q <= '0;
         pretrig_q  <= '0;
         mask_q     <= '0;
         value_q    <= '0;
         edge_q     <= '0;
         prev_q     <= '0;
      end else begin
         prev_q     <= trig_i;
         rd_valid_q <= rd_ok;
         if (abort) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
         end else if (arm && (state_q == IDLE || state_q == DONE)) begin
            mask_q    <= cfg_mask;
            value_q   <= cfg_value;
            edge_q    <= cfg_edge;
            or_q      <= cfg_or;
            pretrig_q <= cfg_pretrig;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            state_q   <= cfg_pretrig != '0 ? PRE : WAIT;
         end else begin
            if (capturing) wr_ptr_q <= wr_ptr_q + ONE;
            case (state_q)
               PRE:
                  if (cnt_q == pretrig_q - ONE) begin
                     cnt_q   <= '0;
                     state_q <= WAIT;
                  end else cnt_q <= cnt_q + ONE;
               WAIT:
                  if (hit) begin
                     trig_pos_q <= wr_ptr_q;
                     cnt_q      <= '0;
                     state_q    <= post_len == '0 ? DONE : POST;
                     done_q     <= post_len == '0;
                  end
               POST:
                  if (cnt_q == post_len - ONE) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else cnt_q <= cnt_q + ONE;
               default: ;
            endcase
         end
      end

   la_sample_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk    (clk),
      .rst    (rst),
      .we_i   (capturing),
      .waddr_i(wr_ptr_q),
      .wdata_i(data_i),
      .re_i   (rd_ok),
      .raddr_i(trig_pos_q - pretrig_q + rd_addr),
      .rdata_o(rd_data)
   );

   assign state_o    = state_q;
   assign done_o     = done_q;
   assign trig_pos_o = trig_pos_q;
   assign rd_valid   = rd_valid_q;
endmodule

// File: doc/la_capture.md
# la_capture

Parametrised on-chip logic-analyzer capture core: the next generation of the fixed 4-bit data / 1-bit trigger probe in the CPU debug path. It samples a configurable-width probe bus into a circular buffer every clock, evaluates a masked multi-channel trigger (level or edge per channel, AND/OR combine), and keeps a programmable number of pre-trigger samples. The finished capture is read back through a simple addressed port by the debug/host side.

## Interface
Parameters:
- DATA_W, 8, probe data width
- TRIG_W, 4, trigger channel count
- DEPTH, 256, buffer depth in samples, power of two, at least 4
- AW, $clog2(DEPTH), address width (derived)

Ports:
- clk  in  1  sole clock; all sampling and readout
- rst  in  1  asynchronous, active-high reset
- data_i  in  DATA_W  probe data, sampled every cycle while capturing
- trig_i  in  TRIG_W  trigger channels
- arm  in  1  start capture (single-cycle pulse)
- abort  in  1  cancel capture, return to IDLE
- cfg_mask  in  TRIG_W  1 = channel participates
- cfg_value  in  TRIG_W  required level / edge target per channel
- cfg_edge  in  TRIG_W  1 = edge mode, 0 = level mode
- cfg_or  in  1  0 = AND combine, 1 = OR combine
- cfg_pretrig  in  AW  pre-trigger sample count
- state_o  out  3  current state encoding
- done_o  out  1  capture complete, buffer readable
- trig_pos_o  out  AW  physical buffer address of trigger sample
- rd_en  in  1  read request
- rd_addr  in  AW  logical address, 0 = oldest sample
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data valid

## Operation
- States: IDLE, PRE, WAIT, POST, DONE.
- arm in IDLE or DONE: latch all cfg_* inputs, clear write pointer and counters, done_o=0; go PRE if pretrig>0, else WAIT. arm in PRE/WAIT/POST ignored.
- abort in any state: go IDLE, done_o=0; abort beats arm in the same cycle.
- PRE, WAIT, POST: data_i written at wr_ptr each cycle, wr_ptr increments mod DEPTH.
- PRE: trigger ignored; after pretrig samples stored, go WAIT.
- WAIT: wraps freely. Hit: store sample, trig_pos_o <= wr_ptr, go POST.
- POST: store DEPTH-1-pretrig samples, then DONE, done_o=1. Total samples = DEPTH. If pretrig = DEPTH-1, POST lasts 0 cycles and DONE follows the trigger cycle.
- Hit logic, per masked channel i:
  - level: trig_i[i]==cfg_value[i].
  - edge: trig_i[i]==cfg_value[i] and trig_prev[i]!=cfg_value[i].
- Hit combine: cfg_or=0 needs all masked channels; cfg_or=1 needs any.
- Mask all zero: forced trigger on the first WAIT cycle, either combine mode.
- trig_prev registers trig_i every cycle in all states, reset 0.
- Readout, DONE only: physical address = (trig_pos - pretrig + rd_addr) mod DEPTH.
- rd_en outside DONE: no RAM access, rd_valid stays 0.

## Timing
- Reset values: state IDLE, done_o 0, trig_pos_o 0, rd_data 0, rd_valid 0, state_o IDLE encoding, trig_prev 0.
- Sample write is same-cycle: data_i present at the rising edge is stored at that edge.
- The trigger sample is the data_i of the cycle whose trig_i produced the hit.
- done_o rises on the edge after the last POST write.
- Read latency is 1 cycle: rd_en/rd_addr at edge N give rd_data and rd_valid at edge N+1. Back-to-back reads are supported. rd_data holds its value when rd_valid=0.
- Reset mid-capture discards the capture; buffer contents are undefined afterwards.

## Structure
- Package la_pkg holds:
  - state enum: IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4 (drives state_o)
  - combine-mode constants: AND=0, OR=1
- Sub-module la_sample_ram: simple dual-port RAM, DEPTH x DATA_W, synchronous write, registered 1-cycle read, no reset on the array.
- The FSM, counters, trigger evaluation and address arithmetic live in la_capture.

## Test plan
- Reset, then idle 10 cycles -> state_o=0, done_o=0, rd_valid=0 with rd_en held high.
- DEPTH=16, pretrig=4, level AND, mask=4'b0011, value=4'b0001, data_i=cycle count, trig matches at sample 20 -> done_o after 11 post samples; rd_addr 0..15 returns 16..31, with the trigger sample at rd_addr 4.
- Edge mode on ch2, value=1, ch2 held high from arm -> no trigger. Ch2 low then high -> trigger on the rising cycle only.
- OR mode, mask=4'b1100, only ch3 matches -> triggers. AND mode, same stimulus -> no trigger. Mask=0 -> trigger on first WAIT cycle.
- Abort during POST -> IDLE next cycle, done_o=0. arm together with abort -> stays IDLE. arm during WAIT -> ignored, trig_pos unchanged.
- pretrig=DEPTH-1 -> DONE on the cycle after the trigger; rd_addr=DEPTH-1 returns the trigger sample; wrap-around addresses verified.
